// File: rtl/prim_ram_scrub_ctrl.sv
// Scrub / initialization initiator for one port of the ECC RAM wrapper.
// An init sweep writes zero to every word. A scrub sweep reads every word,
// writes back corrected data on a correctable error, and counts and logs
// uncorrectable errors. Only one read is ever outstanding.
module prim_ram_scrub_ctrl #(
  parameter int Depth = 512,
  parameter int Width = 32,
  parameter int CntW  = 16,
  localparam int Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             init_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic             ram_gnt_i,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  input  logic [1:0]       ram_rerror_i,
  output logic [CntW-1:0]  corr_cnt_o,
  output logic [CntW-1:0]  uncorr_cnt_o,
  output logic [Aw-1:0]    err_addr_o,
  output logic             err_addr_valid_o
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT_WR,
    RD_REQ,
    RD_WAIT,
    WB_REQ,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [Aw-1:0]     addr_q, addr_d;
  logic [Width-1:0]  wb_data_q, wb_data_d;
  logic              abort_q, abort_d;
  logic [CntW-1:0]   corr_q, corr_d;
  logic [CntW-1:0]   uncorr_q, uncorr_d;
  logic [Aw-1:0]     err_addr_q, err_addr_d;
  logic              err_valid_q, err_valid_d;

  logic accept;
  logic last;
  logic advance;
  logic stop;

  assign accept = ram_req_o & ram_gnt_i;
  assign last   = (addr_q == LastAddr);

  // Outputs decoded from the current state; request fields are held by the
  // state and address registers, so they stay stable until accepted.
  always_comb begin
    busy_o           = (state_q != IDLE);
    done_o           = (state_q == DONE);
    ram_req_o        = (state_q == INIT_WR) || (state_q == RD_REQ) || (state_q == WB_REQ);
    ram_write_o      = (state_q == INIT_WR) || (state_q == WB_REQ);
    ram_addr_o       = addr_q;
    ram_wdata_o      = (state_q == WB_REQ) ? wb_data_q : '0;
    ram_wmask_o      = {Width{ram_req_o}};
    corr_cnt_o       = corr_q;
    uncorr_cnt_o     = uncorr_q;
    err_addr_o       = err_addr_q;
    err_addr_valid_o = err_valid_q;
  end

  // Next-state, address walk, error bookkeeping and abort handling.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wb_data_d   = wb_data_q;
    abort_d     = abort_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    err_addr_d  = err_addr_q;
    err_valid_d = err_valid_q;
    advance     = 1'b0;
    stop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort
        if (start_i) begin
          addr_d  = '0;
          abort_d = 1'b0;
          if (init_i) begin
            state_d = INIT_WR;
          end else begin
            state_d     = RD_REQ;
            corr_d      = '0;
            uncorr_d    = '0;
            err_valid_d = 1'b0;
          end
        end
      end

      INIT_WR: begin
        if (accept) begin
          if (last || abort_i) state_d = DONE;
          else                 addr_d  = addr_q + 1'b1;
        end else if (abort_i) begin
          state_d = DONE;
        end
      end

      RD_REQ: begin
        // An accepted read always completes, so its response is consumed
        // here rather than left dangling into the next sweep.
        if (accept) begin
          state_d = RD_WAIT;
          abort_d = abort_i;
        end else if (abort_i) begin
          state_d = DONE;
        end
      end

      RD_WAIT: begin
        if (abort_i) abort_d = 1'b1;
        if (ram_rvalid_i) begin
          stop = abort_q | abort_i;
          if (ram_rerror_i[1]) begin
            uncorr_d    = (uncorr_q == '1) ? uncorr_q : uncorr_q + 1'b1;
            err_addr_d  = addr_q;
            err_valid_d = 1'b1;
            advance     = 1'b1;
          end else if (ram_rerror_i[0]) begin
            corr_d = (corr_q == '1) ? corr_q : corr_q + 1'b1;
            if (stop) begin
              state_d = DONE;
            end else begin
              wb_data_d = ram_rdata_i;
              state_d   = WB_REQ;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end

      WB_REQ: begin
        if (accept) begin
          stop    = abort_i;
          advance = 1'b1;
        end else if (abort_i) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (stop || last) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = RD_REQ;
      end
    end
  end

  // State and bookkeeping registers; reset returns everything to zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wb_data_q   <= '0;
      abort_q     <= 1'b0;
      corr_q      <= '0;
      uncorr_q    <= '0;
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wb_data_q   <= wb_data_d;
      abort_q     <= abort_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
      err_addr_q  <= err_addr_d;
      err_valid_q <= err_valid_d;
    end
  end

endmodule

// File: tb/tb_prim_ram_scrub_ctrl.sv
// Self-checking bench for prim_ram_scrub_ctrl: a RAM/arbiter responder logs
// every accepted transaction, and a sweep-level model predicts the full
// transaction list and the final counter / log state for each sweep.
module tb_prim_ram_scrub_ctrl;

  localparam int Depth  = 8;
  localparam int Width  = 32;
  localparam int CntW   = 3;
  localparam int Aw     = 3;
  localparam int CntMax = (1 << CntW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, init, abort;
  logic             busy, done, req, wr;
  logic [Aw-1:0]    addr;
  logic [Width-1:0] wdata, wmask;
  logic             gnt, rvalid;
  logic [Width-1:0] rdata;
  logic [1:0]       rerror;
  logic [CntW-1:0]  corr, uncorr;
  logic [Aw-1:0]    err_addr;
  logic             err_v;

  prim_ram_scrub_ctrl #(.Depth(Depth), .Width(Width), .CntW(CntW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .init_i(init), .abort_i(abort),
    .busy_o(busy), .done_o(done), .ram_req_o(req), .ram_write_o(wr),
    .ram_addr_o(addr), .ram_wdata_o(wdata), .ram_wmask_o(wmask),
    .ram_gnt_i(gnt), .ram_rvalid_i(rvalid), .ram_rdata_i(rdata),
    .ram_rerror_i(rerror), .corr_cnt_o(corr), .uncorr_cnt_o(uncorr),
    .err_addr_o(err_addr), .err_addr_valid_o(err_v)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic          wr;
    logic [Aw-1:0] addr;
    logic [31:0]   data;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [1:0]  err_pat [Depth];
  logic [31:0] dat_pat [Depth];

  // responder controls
  bit rand_gnt     = 0;
  bit stray_en     = 0;
  int fix_lat      = 1;
  int stall_addr   = -1;
  int stall_left   = 0;
  int abort_mode   = 0;   // 1: abort in RD_WAIT of abort_addr, 2: abort with accept of write at abort_addr
  int abort_addr   = 0;
  bit abort_w_start = 0;

  // responder state / monitors
  bit            pend = 0;
  int            pend_cnt;
  logic [Aw-1:0] pend_addr;
  bit            abort_next = 0;
  int            done_cnt = 0;
  int            busy_cyc = 0;
  bit            prev_stall = 0;
  logic [Aw-1:0] prev_addr;
  logic          prev_wr;
  logic [31:0]   prev_wdata;

  // model state of the sticky counters / log
  int m_corr = 0, m_unc = 0, m_ea = 0, m_ev = 0;

  // RAM + arbiter responder, acting on the falling edge
  initial begin
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; rerror = '0; abort = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; rvalid = 1'b0; gnt = 1'b0; abort = 1'b0;
        abort_next = 0; prev_stall = 0;
      end else begin
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (prev_stall) begin
          check("hold_req", 64'(req), 64'(1'b1));
          check("hold_addr", 64'(addr), 64'(prev_addr));
          check("hold_wr", 64'(wr), 64'(prev_wr));
          check("hold_wdata", 64'(wdata), 64'(prev_wdata));
        end
        abort = abort_next | abort_w_start;
        abort_next = 0;
        rvalid = 1'b0; rerror = 2'b00; rdata = $urandom;
        if (pend) begin
          if (pend_cnt <= 1) begin
            rvalid = 1'b1; rerror = err_pat[pend_addr]; rdata = dat_pat[pend_addr]; pend = 0;
          end else begin
            pend_cnt--;
          end
        end else if (stray_en && $urandom_range(7) == 0) begin
          rvalid = 1'b1; rerror = 2'b11;
        end
        gnt = rand_gnt ? ($urandom_range(2) != 0) : 1'b1;
        if (req && !wr && int'(addr) == stall_addr && stall_left > 0) begin
          gnt = 1'b0;
          stall_left--;
        end
        prev_stall = req && !gnt;
        prev_addr = addr; prev_wr = wr; prev_wdata = wdata;
        if (req && gnt) begin
          log_q.push_back('{wr, addr, (wr ? wdata : 32'h0)});
          if (wr) begin
            check("wmask", 64'(wmask), 64'(32'hFFFF_FFFF));
            if (abort_mode == 2 && int'(addr) == abort_addr) abort = 1'b1;
          end else begin
            pend = 1;
            pend_cnt = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 3));
            pend_addr = addr;
            if (abort_mode == 1 && int'(addr) == abort_addr) abort_next = 1;
          end
        end
      end
    end
  end

  // Sweep-level model: expected transaction list and sticky state.
  task automatic model(input bit init_m);
    exp_q.delete();
    if (init_m) begin
      for (int a = 0; a < Depth; a++) begin
        exp_q.push_back('{1'b1, Aw'(a), 32'h0});
        if (abort_mode == 2 && a == abort_addr) break;
      end
    end else begin
      m_corr = 0; m_unc = 0; m_ev = 0;
      for (int a = 0; a < Depth; a++) begin
        exp_q.push_back('{1'b0, Aw'(a), 32'h0});
        if (err_pat[a][1]) begin
          if (m_unc < CntMax) m_unc++;
          m_ea = a; m_ev = 1;
        end else if (err_pat[a][0]) begin
          if (m_corr < CntMax) m_corr++;
          if (!(abort_mode == 1 && a == abort_addr)) exp_q.push_back('{1'b1, Aw'(a), dat_pat[a]});
        end
        if (abort_mode == 1 && a == abort_addr) break;
      end
    end
  endtask

  task automatic run_sweep(input bit init_m, input string tag, input bit poke_start);
    log_q.delete();
    done_cnt = 0; busy_cyc = 0;
    model(init_m);
    @(posedge clk); #1;
    start = 1'b1; init = init_m;
    @(posedge clk); #1;
    start = 1'b0; abort_w_start = 0;
    if (poke_start) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1; init = ~init_m;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 1000 && done_cnt == 0; i++) @(posedge clk);
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_n_txn"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check({tag, "_txn"}, 64'(log_q[i]), 64'(exp_q[i]));
    check({tag, "_corr"}, 64'(corr), 64'(m_corr));
    check({tag, "_uncorr"}, 64'(uncorr), 64'(m_unc));
    check({tag, "_err_v"}, 64'(err_v), 64'(m_ev));
    if (m_ev != 0) check({tag, "_err_addr"}, 64'(err_addr), 64'(m_ea));
  endtask

  task automatic set_pat(input logic [1:0] e);
    for (int a = 0; a < Depth; a++) begin
      err_pat[a] = e;
      dat_pat[a] = $urandom;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_req"}, 64'(req), 64'(0));
    check({tag, "_wr"}, 64'(wr), 64'(0));
    check({tag, "_addr"}, 64'(addr), 64'(0));
    check({tag, "_wdata"}, 64'(wdata), 64'(0));
    check({tag, "_wmask"}, 64'(wmask), 64'(0));
    check({tag, "_corr"}, 64'(corr), 64'(0));
    check({tag, "_uncorr"}, 64'(uncorr), 64'(0));
    check({tag, "_err_addr"}, 64'(err_addr), 64'(0));
    check({tag, "_err_v"}, 64'(err_v), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; init = 1'b0;
    set_pat(2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // init sweep, grant tied high
    run_sweep(1'b1, "init", 1'b0);
    check("init_busy_cycles", 64'(busy_cyc), 64'(9));

    // clean scrub
    run_sweep(1'b0, "clean", 1'b0);

    // correctable at 3
    set_pat(2'b00);
    err_pat[3] = 2'b01; dat_pat[3] = 32'hDEAD_BEEF;
    run_sweep(1'b0, "corr3", 1'b0);

    // uncorrectable at 5 and 6
    set_pat(2'b00);
    err_pat[5] = 2'b11; err_pat[6] = 2'b10;
    run_sweep(1'b0, "uncorr56", 1'b0);

    // grant withheld 4 cycles on the read of addr 2
    set_pat(2'b00);
    stall_addr = 2; stall_left = 4;
    run_sweep(1'b0, "stall", 1'b0);
    check("stall_consumed", 64'(stall_left), 64'(0));
    stall_addr = -1;

    // abort while waiting on addr 4, correctable response 3 cycles later
    set_pat(2'b00);
    err_pat[4] = 2'b01;
    abort_mode = 1; abort_addr = 4; fix_lat = 3;
    run_sweep(1'b0, "abort_rdwait", 1'b0);
    abort_mode = 0; fix_lat = 1;
    set_pat(2'b00);
    run_sweep(1'b0, "restart", 1'b0);

    // abort together with a write accept during init
    abort_mode = 2; abort_addr = 5;
    run_sweep(1'b1, "abort_init", 1'b0);
    abort_mode = 0;

    // start with abort in IDLE: start wins
    set_pat(2'b00);
    err_pat[1] = 2'b01;
    abort_w_start = 1;
    run_sweep(1'b0, "start_abort", 1'b0);

    // counter saturation
    set_pat(2'b10);
    run_sweep(1'b0, "sat_uncorr", 1'b0);
    set_pat(2'b01);
    run_sweep(1'b0, "sat_corr", 1'b0);

    // randomized sweeps: random grant, latency, stray rvalid, patterns
    rand_gnt = 1; stray_en = 1; fix_lat = 0;
    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < Depth; a++) begin
        err_pat[a] = 2'($urandom_range(3));
        dat_pat[a] = $urandom;
      end
      run_sweep(1'($urandom_range(3) == 0), "rand", 1'b1);
    end

    // reset in the middle of a sweep
    set_pat(2'b11);
    @(posedge clk); #1 start = 1'b1; init = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    m_corr = 0; m_unc = 0; m_ev = 0; m_ea = 0;
    rand_gnt = 0; stray_en = 0; fix_lat = 1;
    set_pat(2'b00);
    err_pat[0] = 2'b01;
    run_sweep(1'b0, "after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
